// File: rtl/corner_sort.sv
// Frame-end corner sorter: captures four marker targets and assigns them to TL/TR/BL/BR.
// Optional build macro CORNER_SMOOTH_EN enables 3:1 exponential smoothing of accepted corners.
module corner_sort #(
  parameter int unsigned SCREEN_WIDTH  = 1280,
  parameter int unsigned SCREEN_HEIGHT = 720,
  parameter int unsigned MIN_DIAMETER  = 4,
  parameter int unsigned MAX_MISS      = 8,
  localparam int unsigned XW = $clog2(SCREEN_WIDTH),
  localparam int unsigned YW = $clog2(SCREEN_HEIGHT) + 1,
  localparam int unsigned MW = $clog2(MAX_MISS + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [XW-1:0] hcount_in,
  input  logic [YW-1:0] vcount_in,
  input  logic [XW-1:0] xcount0_in,
  input  logic [XW-1:0] xcount1_in,
  input  logic [XW-1:0] xcount2_in,
  input  logic [XW-1:0] xcount3_in,
  input  logic [YW-1:0] ycount0_in,
  input  logic [YW-1:0] ycount1_in,
  input  logic [YW-1:0] ycount2_in,
  input  logic [YW-1:0] ycount3_in,
  input  logic [YW-1:0] diameter0_in,
  input  logic [YW-1:0] diameter1_in,
  input  logic [YW-1:0] diameter2_in,
  input  logic [YW-1:0] diameter3_in,
  input  logic [3:0]    valid_in,
  output logic [XW-1:0] tl_x_out,
  output logic [XW-1:0] tr_x_out,
  output logic [XW-1:0] bl_x_out,
  output logic [XW-1:0] br_x_out,
  output logic [YW-1:0] tl_y_out,
  output logic [YW-1:0] tr_y_out,
  output logic [YW-1:0] bl_y_out,
  output logic [YW-1:0] br_y_out,
  output logic          strobe_out,
  output logic          good_out,
  output logic          locked_out,
  output logic [MW-1:0] miss_cnt_out
);

  typedef enum logic [2:0] {StIdle, StCapture, StScan, StCheck, StUpdate} state_e;

  state_e state_q, state_d;
  logic   capture_en, scan_en, check_en, update_en;
  logic   frame_end;

  logic [XW-1:0] in_x   [4];
  logic [YW-1:0] in_y   [4];
  logic [YW-1:0] in_dia [4];

  logic [XW-1:0] cap_x_q [4];
  logic [YW-1:0] cap_y_q [4];
  logic [3:0]    usable_q;

  // Corner slot order everywhere: 0 TL, 1 TR, 2 BL, 3 BR.
  logic [1:0]             sel_idx_q [4];
  logic [1:0]             scan_idx_q;
  logic                   have_q;
  logic [XW:0]            min_s_q, max_s_q;
  logic signed [XW+1:0]   max_d_q, min_d_q;
  logic [XW-1:0]          cur_x;
  logic [YW-1:0]          cur_y;
  logic [XW:0]            cur_s;
  logic signed [XW+1:0]   cur_d;
  logic                   distinct;
  logic                   accept_q;

  logic [XW-1:0] corner_x_q [4];
  logic [YW-1:0] corner_y_q [4];
  logic [XW-1:0] new_x      [4];
  logic [YW-1:0] new_y      [4];
  logic [XW-1:0] load_x     [4];
  logic [YW-1:0] load_y     [4];
`ifdef CORNER_SMOOTH_EN
  logic [XW+1:0] blend_x [4];
  logic [YW+1:0] blend_y [4];
`endif

  logic          strobe_q, good_q, locked_q;
  logic [MW-1:0] miss_q;
  logic [MW-1:0] miss_inc;

  assign in_x[0]   = xcount0_in;
  assign in_x[1]   = xcount1_in;
  assign in_x[2]   = xcount2_in;
  assign in_x[3]   = xcount3_in;
  assign in_y[0]   = ycount0_in;
  assign in_y[1]   = ycount1_in;
  assign in_y[2]   = ycount2_in;
  assign in_y[3]   = ycount3_in;
  assign in_dia[0] = diameter0_in;
  assign in_dia[1] = diameter1_in;
  assign in_dia[2] = diameter2_in;
  assign in_dia[3] = diameter3_in;

  assign frame_end = (hcount_in == XW'(SCREEN_WIDTH - 1)) &&
                     (vcount_in == YW'(SCREEN_HEIGHT - 1));

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (frame_end) state_d = StCapture;
      StCapture: state_d = StScan;
      StScan:    if (scan_idx_q == 2'd3) state_d = StCheck;
      StCheck:   state_d = StUpdate;
      StUpdate:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM: control outputs
  always_comb begin
    capture_en = (state_q == StCapture);
    scan_en    = (state_q == StScan);
    check_en   = (state_q == StCheck);
    update_en  = (state_q == StUpdate);
  end

  assign cur_x = cap_x_q[scan_idx_q];
  assign cur_y = cap_y_q[scan_idx_q];
  assign cur_s = (XW+1)'(cur_x) + (XW+1)'(cur_y);
  assign cur_d = $signed((XW+2)'(cur_x)) - $signed((XW+2)'(cur_y));

  assign distinct = (sel_idx_q[0] != sel_idx_q[1]) && (sel_idx_q[0] != sel_idx_q[2]) &&
                    (sel_idx_q[0] != sel_idx_q[3]) && (sel_idx_q[1] != sel_idx_q[2]) &&
                    (sel_idx_q[1] != sel_idx_q[3]) && (sel_idx_q[2] != sel_idx_q[3]);

  // Capture, sequential scan and acceptance check.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 4; i++) begin
        cap_x_q[i]   <= '0;
        cap_y_q[i]   <= '0;
        sel_idx_q[i] <= '0;
      end
      usable_q   <= '0;
      scan_idx_q <= '0;
      have_q     <= 1'b0;
      min_s_q    <= '0;
      max_s_q    <= '0;
      max_d_q    <= '0;
      min_d_q    <= '0;
      accept_q   <= 1'b0;
    end else begin
      if (capture_en) begin
        for (int i = 0; i < 4; i++) begin
          cap_x_q[i]  <= in_x[i];
          cap_y_q[i]  <= in_y[i];
          usable_q[i] <= valid_in[3-i] && (in_dia[i] >= YW'(MIN_DIAMETER));
        end
        scan_idx_q <= '0;
        have_q     <= 1'b0;
      end
      if (scan_en) begin
        scan_idx_q <= scan_idx_q + 2'd1;
        // Strict compares: an equal later candidate never displaces an earlier one.
        if (usable_q[scan_idx_q]) begin
          have_q <= 1'b1;
          if (!have_q || (cur_s < min_s_q)) begin
            min_s_q      <= cur_s;
            sel_idx_q[0] <= scan_idx_q;
          end
          if (!have_q || (cur_d > max_d_q)) begin
            max_d_q      <= cur_d;
            sel_idx_q[1] <= scan_idx_q;
          end
          if (!have_q || (cur_d < min_d_q)) begin
            min_d_q      <= cur_d;
            sel_idx_q[2] <= scan_idx_q;
          end
          if (!have_q || (cur_s > max_s_q)) begin
            max_s_q      <= cur_s;
            sel_idx_q[3] <= scan_idx_q;
          end
        end
      end
      if (check_en) accept_q <= (&usable_q) && distinct;
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      new_x[c] = cap_x_q[sel_idx_q[c]];
      new_y[c] = cap_y_q[sel_idx_q[c]];
`ifdef CORNER_SMOOTH_EN
      blend_x[c] = ((XW+2)'(corner_x_q[c]) << 1) + (XW+2)'(corner_x_q[c]) + (XW+2)'(new_x[c]);
      blend_y[c] = ((YW+2)'(corner_y_q[c]) << 1) + (YW+2)'(corner_y_q[c]) + (YW+2)'(new_y[c]);
      // Without a current lock the old corners are stale, so snap straight to the new ones.
      load_x[c]  = locked_q ? blend_x[c][XW+1:2] : new_x[c];
      load_y[c]  = locked_q ? blend_y[c][YW+1:2] : new_y[c];
`else
      load_x[c]  = new_x[c];
      load_y[c]  = new_y[c];
`endif
    end
  end

  assign miss_inc = miss_q + 1'b1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int c = 0; c < 4; c++) begin
        corner_x_q[c] <= '0;
        corner_y_q[c] <= '0;
      end
      strobe_q <= 1'b0;
      good_q   <= 1'b0;
      locked_q <= 1'b0;
      miss_q   <= '0;
    end else begin
      strobe_q <= update_en;
      if (update_en) begin
        if (accept_q) begin
          for (int c = 0; c < 4; c++) begin
            corner_x_q[c] <= load_x[c];
            corner_y_q[c] <= load_y[c];
          end
          good_q   <= 1'b1;
          locked_q <= 1'b1;
          miss_q   <= '0;
        end else begin
          good_q <= 1'b0;
          if (miss_q != MW'(MAX_MISS)) miss_q <= miss_inc;
          if (miss_q >= MW'(MAX_MISS - 1)) locked_q <= 1'b0;
        end
      end
    end
  end

  assign tl_x_out     = corner_x_q[0];
  assign tr_x_out     = corner_x_q[1];
  assign bl_x_out     = corner_x_q[2];
  assign br_x_out     = corner_x_q[3];
  assign tl_y_out     = corner_y_q[0];
  assign tr_y_out     = corner_y_q[1];
  assign bl_y_out     = corner_y_q[2];
  assign br_y_out     = corner_y_q[3];
  assign strobe_out   = strobe_q;
  assign good_out     = good_q;
  assign locked_out   = locked_q;
  assign miss_cnt_out = miss_q;

endmodule

// File: tb/tb_corner_sort.sv
// Directed self-checking bench for corner_sort with hand-computed corner sets.
// Expectations for the smoothing case follow the CORNER_SMOOTH_EN macro of the build.
module tb_corner_sort;

  localparam int XW = 11;
  localparam int YW = 11;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [XW-1:0] hcount;
  logic [YW-1:0] vcount;
  logic [XW-1:0] tx [4];
  logic [YW-1:0] ty [4];
  logic [YW-1:0] td [4];
  logic [3:0]    tv;

  logic [XW-1:0] tl_x, tr_x, bl_x, br_x;
  logic [YW-1:0] tl_y, tr_y, bl_y, br_y;
  logic          strobe, good, locked;
  logic [MW-1:0] miss;

  int n_vec = 0;
  int n_err = 0;

  corner_sort dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .hcount_in    (hcount),
    .vcount_in    (vcount),
    .xcount0_in   (tx[0]),
    .xcount1_in   (tx[1]),
    .xcount2_in   (tx[2]),
    .xcount3_in   (tx[3]),
    .ycount0_in   (ty[0]),
    .ycount1_in   (ty[1]),
    .ycount2_in   (ty[2]),
    .ycount3_in   (ty[3]),
    .diameter0_in (td[0]),
    .diameter1_in (td[1]),
    .diameter2_in (td[2]),
    .diameter3_in (td[3]),
    .valid_in     (tv),
    .tl_x_out     (tl_x),
    .tr_x_out     (tr_x),
    .bl_x_out     (bl_x),
    .br_x_out     (br_x),
    .tl_y_out     (tl_y),
    .tr_y_out     (tr_y),
    .bl_y_out     (bl_y),
    .br_y_out     (br_y),
    .strobe_out   (strobe),
    .good_out     (good),
    .locked_out   (locked),
    .miss_cnt_out (miss)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag, input int g, input int lck, input int m);
    check_eq({tag, ".good"}, int'(good), g);
    check_eq({tag, ".locked"}, int'(locked), lck);
    check_eq({tag, ".miss"}, int'(miss), m);
  endtask

  task automatic check_corners(input string tag, input int tlx, input int tly,
                               input int trx, input int tr_yv, input int blx, input int bly,
                               input int brx, input int bry);
    check_eq({tag, ".tl_x"}, int'(tl_x), tlx);
    check_eq({tag, ".tl_y"}, int'(tl_y), tly);
    check_eq({tag, ".tr_x"}, int'(tr_x), trx);
    check_eq({tag, ".tr_y"}, int'(tr_y), tr_yv);
    check_eq({tag, ".bl_x"}, int'(bl_x), blx);
    check_eq({tag, ".bl_y"}, int'(bl_y), bly);
    check_eq({tag, ".br_x"}, int'(br_x), brx);
    check_eq({tag, ".br_y"}, int'(br_y), bry);
  endtask

  task automatic set_a();
    tx = '{11'd100, 11'd1000, 11'd120, 11'd1100};
    ty = '{11'd100, 11'd120, 11'd600, 11'd650};
    td = '{11'd20, 11'd20, 11'd20, 11'd20};
    tv = 4'b1111;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    hcount = 11'd1279;
    vcount = 11'd719;
    @(negedge clk);
    hcount = '0;
    vcount = '0;
  endtask

  // Counts sampling points after the frame-end edge until strobe, bounded.
  task automatic wait_strobe(output int lat);
    lat = 1;
    while (!strobe && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_frame(input string tag);
    int lat;
    pulse_frame();
    wait_strobe(lat);
    check_eq({tag, ".latency"}, lat, 8);
    @(negedge clk);
    check_eq({tag, ".strobe_drop"}, int'(strobe), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nstb;
    rst    = 1'b1;
    hcount = '0;
    vcount = '0;
    set_a();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset.strobe", int'(strobe), 0);
    check_status("reset", 0, 0, 0);
    check_corners("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    run_frame("set_a");
    check_status("set_a", 1, 1, 0);
    check_corners("set_a", 100, 100, 1000, 120, 120, 600, 1100, 650);

    tx = '{11'd1100, 11'd120, 11'd1000, 11'd100};
    ty = '{11'd650, 11'd600, 11'd120, 11'd100};
    run_frame("perm");
    check_status("perm", 1, 1, 0);
    check_corners("perm", 100, 100, 1000, 120, 120, 600, 1100, 650);

    set_a();
    td[2] = 11'd3;
    run_frame("small_dia");
    check_status("small_dia", 0, 1, 1);
    check_corners("small_dia", 100, 100, 1000, 120, 120, 600, 1100, 650);

    set_a();
    run_frame("recover");
    check_status("recover", 1, 1, 0);

    tv = 4'b0111;
    for (int i = 1; i <= 9; i++) begin
      run_frame("miss");
      if (i == 7) check_status("miss7", 0, 1, 7);
      if (i == 8) check_status("miss8", 0, 0, 8);
    end
    check_status("miss_sat", 0, 0, 8);
    check_corners("miss_hold", 100, 100, 1000, 120, 120, 600, 1100, 650);

    tv = 4'b1111;
    run_frame("relock");
    check_status("relock", 1, 1, 0);

    pulse_frame();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nstb = 0;
    repeat (15) begin
      @(negedge clk);
      if (strobe) nstb++;
    end
    check_eq("abort.strobes", nstb, 0);
    check_status("abort", 0, 0, 0);
    check_corners("abort", 0, 0, 0, 0, 0, 0, 0, 0);

    run_frame("after_abort");
    check_status("after_abort", 1, 1, 0);
    check_corners("after_abort", 100, 100, 1000, 120, 120, 600, 1100, 650);

    // A second frame end while busy must not start another evaluation.
    pulse_frame();
    pulse_frame();
    nstb = 0;
    repeat (25) begin
      @(negedge clk);
      if (strobe) nstb++;
    end
    check_eq("busy_frame.strobes", nstb, 1);

    tx[0] = 11'd140;
    run_frame("smooth");
    check_status("smooth", 1, 1, 0);
`ifdef CORNER_SMOOTH_EN
    check_corners("smooth", 110, 100, 1000, 120, 120, 600, 1100, 650);
`else
    check_corners("smooth", 140, 100, 1000, 120, 120, 600, 1100, 650);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
